// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Program-counter sequencer and instruction-fetch controller for the RV32
//   core. Owns the PC, issues one instruction-memory request at a time and
//   holds the returned word for decode until it is acknowledged.
//
// Ports
//   clk, rst        core clock; asynchronous active-high reset
//   redirect_valid  control-flow change requested this cycle
//   pc_sel          3'b000 = ALU target (jalr), 3'b011 = br_pc + ext_imm,
//                   any other code is treated as "no redirect"
//   alu_out         jalr target from the ALU
//   ext_imm         sign-extended branch/jal offset
//   br_pc           PC of the redirecting instruction (base for IMM_PC)
//   stall           downstream hazard, blocks consumption of the held word
//   imem_req        fetch request (high only while a fetch is outstanding)
//   imem_addr       fetch address, equal to the PC register
//   imem_ready      memory returns imem_rdata this cycle
//   imem_rdata      instruction word from memory
//   inst_valid      inst / inst_pc hold a deliverable instruction
//   inst, inst_pc   held instruction and its address
//   inst_ack        decode consumes the held instruction
//   misalign_err    sticky: a redirect target was not word aligned
//   fetch_cnt       number of instructions delivered (acknowledged)

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] alu_out,
  input  logic [31:0] ext_imm,
  input  logic [31:0] br_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ack,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt
);

  localparam logic [2:0] SEL_ALU_OUT = 3'b000;
  localparam logic [2:0] SEL_IMM_PC  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [31:0] pc_reg;
  logic [31:0] pending_pc_reg;
  logic        discard_reg;
  logic [31:0] inst_reg;
  logic [31:0] inst_pc_reg;
  logic        misalign_err_reg;
  logic [31:0] fetch_cnt_reg;

  // Redirect decode: only the two recognised select codes count as a redirect.
  logic        redirect_take;
  logic [31:0] redirect_target;
  logic        target_misaligned;

  always_comb begin
    redirect_take   = redirect_valid && (pc_sel == SEL_ALU_OUT || pc_sel == SEL_IMM_PC);
    // jalr clears bit 0 of the computed address; branch/jal add with wrap-around.
    redirect_target = (pc_sel == SEL_ALU_OUT) ? (alu_out & 32'hFFFF_FFFE)
                                              : (br_pc + ext_imm);
    target_misaligned = (redirect_target[1:0] != 2'b00);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (redirect_take) begin
          state_next = target_misaligned ? HALT : REQ;
        end else if (imem_ready && !discard_reg) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        // A redirect outranks acknowledge and stall: the held word is dropped.
        if (redirect_take) begin
          state_next = target_misaligned ? HALT : REQ;
        end else if (inst_ack && !stall) begin
          state_next = REQ;
        end
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (combinational from state so reset drops the request at once)
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req     = (state_reg == REQ);
    inst_valid   = (state_reg == HOLD);
    imem_addr    = pc_reg;
    inst         = inst_reg;
    inst_pc      = inst_pc_reg;
    misalign_err = misalign_err_reg;
    fetch_cnt    = fetch_cnt_reg;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg           <= RESET_PC;
      pending_pc_reg   <= RESET_PC;
      discard_reg      <= 1'b0;
      inst_reg         <= 32'h0;
      inst_pc_reg      <= 32'h0;
      misalign_err_reg <= 1'b0;
      fetch_cnt_reg    <= 32'h0;
    end else begin
      case (state_reg)
        REQ: begin
          if (redirect_take) begin
            if (target_misaligned) begin
              misalign_err_reg <= 1'b1;
              discard_reg      <= 1'b0;
            end else if (imem_ready) begin
              // Response arriving now belongs to the old path; drop it and
              // start the new path immediately.
              pc_reg      <= redirect_target;
              discard_reg <= 1'b0;
            end else begin
              // The address must stay stable while the request is pending,
              // so park the target until the old response drains. A later
              // redirect simply overwrites it (youngest wins).
              pending_pc_reg <= redirect_target;
              discard_reg    <= 1'b1;
            end
          end else if (imem_ready) begin
            if (discard_reg) begin
              pc_reg      <= pending_pc_reg;
              discard_reg <= 1'b0;
            end else begin
              inst_reg    <= imem_rdata;
              inst_pc_reg <= pc_reg;
              pc_reg      <= pc_reg + 32'd4;
            end
          end
        end
        HOLD: begin
          if (redirect_take) begin
            if (target_misaligned) begin
              misalign_err_reg <= 1'b1;
            end else begin
              pc_reg <= redirect_target;
            end
          end else if (inst_ack && !stall) begin
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
          end
        end
        default: begin
          // IDLE and HALT leave the datapath untouched.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.

module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [2:0]  pc_sel;
  logic [31:0] alu_out, ext_imm, br_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        inst_ack;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .pc_sel(pc_sel),
    .alu_out(alu_out), .ext_imm(ext_imm), .br_pc(br_pc),
    .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ack(inst_ack),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0; pc_sel = 3'b001;
    alu_out = 32'h0; ext_imm = 32'h0; br_pc = 32'h0;
    stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; inst_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) step();
    chk("reset.imem_req",     32'(imem_req), 32'h0);
    chk("reset.imem_addr",    imem_addr, RST_PC);
    chk("reset.inst_valid",   32'(inst_valid), 32'h0);
    chk("reset.inst",         inst, 32'h0);
    chk("reset.inst_pc",      inst_pc, 32'h0);
    chk("reset.misalign_err", 32'(misalign_err), 32'h0);
    chk("reset.fetch_cnt",    fetch_cnt, 32'h0);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rv;
    logic [2:0]  sel;
    logic [31:0] alu, imm, brpc;
    logic        stl, rdy;
    logic [31:0] rdata;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst, e_ipc;
    logic        e_err;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic rv, input logic [2:0] sel, input logic [31:0] alu,
      input logic [31:0] imm, input logic [31:0] brpc, input logic stl,
      input logic rdy, input logic [31:0] rdata, input logic ack,
      input logic e_req, input logic [31:0] e_addr, input logic e_valid,
      input logic [31:0] e_inst, input logic [31:0] e_ipc, input logic [31:0] e_cnt);
    vec_t v;
    v.rv = rv; v.sel = sel; v.alu = alu; v.imm = imm; v.brpc = brpc;
    v.stl = stl; v.rdy = rdy; v.rdata = rdata; v.ack = ack;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_err = 1'b0; v.e_cnt = e_cnt;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural reference model (fetch described as "busy fetching" vs
  // "holding a word", with a queue holding at most the youngest deferred target)
  // ---------------------------------------------------------------------------
  bit          m_started, m_hold, m_halt, m_err;
  logic [31:0] m_pc, m_inst, m_ipc, m_cnt;
  logic [31:0] m_pend[$];

  task automatic model_reset();
    m_started = 0; m_hold = 0; m_halt = 0; m_err = 0;
    m_pc = RST_PC; m_inst = 0; m_ipc = 0; m_cnt = 0;
    m_pend.delete();
  endtask

  task automatic model_update();
    bit          take;
    logic [31:0] tgt;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_halt) return;
    if (!m_started) begin
      m_started = 1;
      return;
    end
    take = redirect_valid && (pc_sel == 3'd0 || pc_sel == 3'd3);
    tgt  = (pc_sel == 3'd0) ? {alu_out[31:1], 1'b0} : br_pc + ext_imm;
    if (take && (tgt % 4 != 0)) begin
      m_err = 1; m_halt = 1; m_hold = 0;
      m_pend.delete();
    end else if (m_hold) begin
      if (take) begin
        m_pc = tgt; m_hold = 0;
      end else if (inst_ack && !stall) begin
        m_cnt = m_cnt + 1; m_hold = 0;
      end
    end else if (take) begin
      m_pend.delete();
      if (imem_ready) m_pc = tgt;
      else m_pend.push_back(tgt);
    end else if (imem_ready) begin
      if (m_pend.size() > 0) begin
        m_pc = m_pend.pop_front();
      end else begin
        m_inst = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 4; m_hold = 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // ---------------- vector table ----------------
    //            rv sel    alu            imm            brpc           stl rdy rdata          ack  req addr           val inst           ipc            cnt
    vecs.push_back(mk(0, 3'd1, 32'h0,        32'h0,         32'h0,         0, 1, 32'h13,         1,   1, 32'h3000, 0, 32'h0,         32'h0,    0));
    vecs.push_back(mk(0, 3'd1, 32'h0,        32'h0,         32'h0,         0, 1, 32'h13,         1,   0, 32'h3004, 1, 32'h13,        32'h3000, 0));
    vecs.push_back(mk(0, 3'd1, 32'h0,        32'h0,         32'h0,         0, 1, 32'h13,         1,   1, 32'h3004, 0, 32'h13,        32'h3000, 1));
    vecs.push_back(mk(0, 3'd1, 32'h0,        32'h0,         32'h0,         0, 1, 32'h13,         1,   0, 32'h3008, 1, 32'h13,        32'h3004, 1));
    vecs.push_back(mk(0, 3'd1, 32'h0,        32'h0,         32'h0,         0, 1, 32'h13,         1,   1, 32'h3008, 0, 32'h13,        32'h3004, 2));
    vecs.push_back(mk(0, 3'd1, 32'h0,        32'h0,         32'h0,         0, 1, 32'h13,         1,   0, 32'h300C, 1, 32'h13,        32'h3008, 2));
    vecs.push_back(mk(0, 3'd1, 32'h0,        32'h0,         32'h0,         0, 1, 32'h13,         1,   1, 32'h300C, 0, 32'h13,        32'h3008, 3));
    vecs.push_back(mk(0, 3'd1, 32'h0,        32'h0,         32'h0,         0, 1, 32'h00100093,   0,   0, 32'h3010, 1, 32'h00100093,  32'h300C, 3));
    // HOLD redirect (IMM_PC 0x3010 + -16) outranks ack; count unchanged
    vecs.push_back(mk(1, 3'd3, 32'h0,        32'hFFFF_FFF0, 32'h3010,      0, 1, 32'hBAD,        1,   1, 32'h3000, 0, 32'h00100093,  32'h300C, 3));
    vecs.push_back(mk(0, 3'd1, 32'h0,        32'h0,         32'h0,         0, 1, 32'h13,         0,   0, 32'h3004, 1, 32'h13,        32'h3000, 3));
    // unrecognised select codes are ignored
    vecs.push_back(mk(1, 3'd2, 32'h5003,     32'h2,         32'h3000,      0, 1, 32'h0,          0,   0, 32'h3004, 1, 32'h13,        32'h3000, 3));
    vecs.push_back(mk(1, 3'd7, 32'h5003,     32'h2,         32'h3000,      0, 1, 32'h0,          1,   1, 32'h3004, 0, 32'h13,        32'h3000, 4));
    vecs.push_back(mk(1, 3'd2, 32'h5003,     32'h2,         32'h3000,      0, 1, 32'h22,         0,   0, 32'h3008, 1, 32'h22,        32'h3004, 4));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      redirect_valid = vecs[i].rv; pc_sel = vecs[i].sel;
      alu_out = vecs[i].alu; ext_imm = vecs[i].imm; br_pc = vecs[i].brpc;
      stall = vecs[i].stl; imem_ready = vecs[i].rdy;
      imem_rdata = vecs[i].rdata; inst_ack = vecs[i].ack;
      step();
      chk($sformatf("vec%0d.imem_req", i),     32'(imem_req),     32'(vecs[i].e_req));
      chk($sformatf("vec%0d.imem_addr", i),    imem_addr,         vecs[i].e_addr);
      chk($sformatf("vec%0d.inst_valid", i),   32'(inst_valid),   32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.inst", i),         inst,              vecs[i].e_inst);
      chk($sformatf("vec%0d.inst_pc", i),      inst_pc,           vecs[i].e_ipc);
      chk($sformatf("vec%0d.misalign_err", i), 32'(misalign_err), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d.fetch_cnt", i),    fetch_cnt,         vecs[i].e_cnt);
    end

    // ---------------- stall while held (state HOLD, inst 0x22 @0x3004) ----------------
    idle_inputs();
    stall = 1'b1; inst_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall.inst_valid", 32'(inst_valid), 32'h1);
      chk("stall.inst",       inst, 32'h22);
      chk("stall.fetch_cnt",  fetch_cnt, 32'd4);
    end
    stall = 1'b0;
    step();
    chk("unstall.fetch_cnt", fetch_cnt, 32'd5);
    chk("unstall.imem_req",  32'(imem_req), 32'h1);
    chk("unstall.imem_addr", imem_addr, 32'h3004 + 32'd4);

    // ---------------- redirect while request waits on memory ----------------
    idle_inputs();
    redirect_valid = 1'b1; pc_sel = 3'b000; alu_out = 32'h4001;
    step();
    chk("wait0.imem_addr", imem_addr, 32'h3008);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("wait.imem_req",  32'(imem_req), 32'h1);
      chk("wait.imem_addr", imem_addr, 32'h3008);
    end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("drain.inst_valid", 32'(inst_valid), 32'h0);
    chk("drain.imem_addr",  imem_addr, 32'h4000);
    imem_rdata = 32'h33;
    step();
    chk("newpath.inst_valid", 32'(inst_valid), 32'h1);
    chk("newpath.inst",       inst, 32'h33);
    chk("newpath.inst_pc",    inst_pc, 32'h4000);

    // ---------------- misaligned redirect, halt, async reset ----------------
    idle_inputs();
    redirect_valid = 1'b1; pc_sel = 3'b011; br_pc = 32'h3000; ext_imm = 32'h2;
    imem_ready = 1'b1; inst_ack = 1'b1;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("halt.misalign_err", 32'(misalign_err), 32'h1);
      chk("halt.imem_req",     32'(imem_req), 32'h0);
      chk("halt.inst_valid",   32'(inst_valid), 32'h0);
      chk("halt.fetch_cnt",    fetch_cnt, 32'd5);
      step();
    end
    rst = 1'b1;
    #1;
    chk("arst.misalign_err", 32'(misalign_err), 32'h0);
    chk("arst.imem_addr",    imem_addr, RST_PC);
    step();
    rst = 1'b0;
    step();
    chk("restart.imem_req",  32'(imem_req), 32'h1);
    chk("restart.imem_addr", imem_addr, RST_PC);
    #2 rst = 1'b1;
    #1;
    chk("midfetch_rst.imem_req", 32'(imem_req), 32'h0);
    step();

    // ---------------- randomized run against the model ----------------
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit bad;
      rst = (m_halt && $urandom_range(0, 7) == 0) || ($urandom_range(0, 399) == 0);
      redirect_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 4))
        0: pc_sel = 3'd0;
        1: pc_sel = 3'd3;
        2: pc_sel = 3'd2;
        3: pc_sel = 3'd7;
        default: pc_sel = 3'($urandom_range(0, 7));
      endcase
      bad     = ($urandom_range(0, 29) == 0);
      alu_out = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 1)) | (bad ? 32'h2 : 32'h0);
      br_pc   = $urandom & 32'hFFFF_FFFC;
      ext_imm = ($urandom_range(0, 1) == 1) ? (($urandom | 32'hFFFF_F000) & 32'hFFFF_FFFC)
                                            : ($urandom & 32'h0000_0FFC);
      ext_imm = ext_imm | (bad ? 32'h2 : 32'h0);
      stall      = ($urandom_range(0, 9) < 3);
      imem_ready = ($urandom_range(0, 9) < 6);
      imem_rdata = $urandom;
      inst_ack   = ($urandom_range(0, 9) < 7);
      model_update();
      step();
      chk("rnd.imem_req",     32'(imem_req),     32'(m_started && !m_hold && !m_halt));
      chk("rnd.imem_addr",    imem_addr,         m_pc);
      chk("rnd.inst_valid",   32'(inst_valid),   32'(m_hold));
      chk("rnd.inst",         inst,              m_inst);
      chk("rnd.inst_pc",      inst_pc,           m_ipc);
      chk("rnd.misalign_err", 32'(misalign_err), 32'(m_err));
      chk("rnd.fetch_cnt",    fetch_cnt,         m_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
